dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 32x32 data memory (DM) used by the rv32i pipeline.
- Requester 0 is the core MEM stage (LW/SW). Requester 1 is the program/data loader used to preload DM and read back results.
- Issues one transaction at a time to the memory port, handles fixed read latency and returns read data.
- Round-robin between requesters, with a bounded loader lock for burst preload.

Parameters:
- AW, 5, word-address width (32 words).
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the M_EN cycle to valid M_RDATA (legal 1..7).
- MAX_LOCK, 8, maximum consecutive locked loader grants while the core is waiting (legal 1..255).

Ports:
- clk  in  1  clock, all logic on posedge.
- RN  in  1  synchronous active-high reset.
- C_REQ  in  1  core request; held with C_WE/C_ADDR/C_WDATA stable until C_GNT is sampled high.
- C_WE  in  1  core write enable (1 = SW, 0 = LW).
- C_ADDR  in  AW  core word address.
- C_WDATA  in  DW  core write data.
- C_GNT  out  1  core grant pulse, one cycle.
- C_RVALID  out  1  core read-data valid pulse, one cycle.
- C_RDATA  out  DW  core read data; held until the next core C_RVALID.
- C_STALL  out  1  C_REQ & ~C_GNT; tells the pipeline to freeze.
- L_REQ, L_WE, L_ADDR, L_WDATA  in  1/1/AW/DW  loader request, same rules as the core port.
- L_LOCK  in  1  loader requests burst priority.
- L_GNT, L_RVALID, L_RDATA  out  1/1/DW  loader equivalents of C_GNT, C_RVALID, C_RDATA.
- M_EN, M_WE  out  1  memory enable and write strobe.
- M_ADDR  out  AW  memory address.
- M_WDATA  out  DW  memory write data.
- M_RDATA  in  DW  memory read data.

Behaviour:
- Reset (RN high at posedge):
  - State returns to IDLE.
  - All GNT, RVALID and M_EN/M_WE outputs go to 0; RDATA, M_ADDR and M_WDATA go to 0.
  - LAST = 1, so the core wins the first tie; LOCK_ACT = 0; lock counter = 0.
  - Reset mid-read discards the pending read, and no RVALID is issued for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any eligible REQ is present, pick a winner at the edge.
  - Register the winner's WE/ADDR/WDATA onto M_*, assert its GNT and M_EN, and go to ISSUE.
  - If no eligible REQ is present, stay in IDLE with all strobes 0.
- ISSUE (exactly one cycle):
  - M_EN = 1, M_WE = captured WE, GNT of the winner = 1.
  - If the transaction is a write, go to IDLE; the memory writes at the end of ISSUE.
  - If it is a read, load the wait counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - M_EN = 0; decrement the counter each cycle.
  - M_RDATA is valid in cycle ISSUE+RD_LAT. At that edge, capture it into the winner's RDATA and pulse the winner's RVALID in the following cycle.
  - Go to IDLE at the same edge.
  - With RD_LAT = 1 the WAIT state lasts one cycle.
- Throughput and latency:
  - A write occupies 2 cycles (IDLE + ISSUE) per transaction.
  - A read occupies 2 + RD_LAT cycles.
  - REQ at cycle T gives GNT at T+1 and, for a read, RVALID at T+2+RD_LAT.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high, lock not active: grant the requester not in LAST, then update LAST to the winner.
  - REQs seen during ISSUE or WAIT are ignored and must be held.
- Lock:
  - LOCK_ACT is set when the loader is granted with L_LOCK = 1.
  - While LOCK_ACT is set, the loader wins every tie and the lock counter increments on each loader grant while C_REQ is high.
  - When the counter reaches MAX_LOCK, the next tie goes to the core; then the counter clears and LOCK_ACT stays set.
  - LOCK_ACT clears in IDLE when L_LOCK = 0, and the counter clears with it.
  - A core request with no loader request is always granted, even while locked.
- A requester may drop REQ before being granted (abandon). No grant then occurs unless the requester was already selected at that edge.
- Addresses wrap modulo 2^AW. The arbiter does no range checking.
- GNT_0 and GNT_1 are never high together, and RVALID pulses for the two ports never overlap.

Test Plan:
- Reset, then C_REQ=1, C_WE=1, C_ADDR=3, C_WDATA=0x00000003 → C_GNT at T+1 with M_EN=1, M_WE=1, M_ADDR=3, M_WDATA=3; FSM back in IDLE at T+2.
- Core read of address 3 (memory model returns 0x3 after RD_LAT=1) → C_GNT at T+1, C_RVALID at T+3 with C_RDATA=0x00000003; L_RVALID stays 0.
- C_REQ and L_REQ both held from reset → grants alternate C, L, C, L; no two GNTs in the same cycle; C_STALL high in every cycle the core waits.
- L_LOCK=1 with both requesting continuously and MAX_LOCK=2 → grant order L, L, L, C, L, L, C; drop L_LOCK → round-robin resumes.
- Assert RN during WAIT of a loader read (RD_LAT=3) → no L_RVALID, all outputs 0, next core request granted 1 cycle after RN falls.
- Run RD_LAT=4 with back-to-back core reads of addresses 0..31 → each read takes 6 cycles, C_RDATA matches the model, and address 31 is followed by 0 when wrapped with C_ADDR+1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: core (port C)
// and loader (port L), round-robin with a bounded loader burst lock.
module dmem_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          RN,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_WDATA,
  output logic          C_GNT,
  output logic          C_RVALID,
  output logic [DW-1:0] C_RDATA,
  output logic          C_STALL,
  input  logic          L_REQ,
  input  logic          L_WE,
  input  logic [AW-1:0] L_ADDR,
  input  logic [DW-1:0] L_WDATA,
  input  logic          L_LOCK,
  output logic          L_GNT,
  output logic          L_RVALID,
  output logic [DW-1:0] L_RDATA,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);
  localparam logic [7:0] LOCK_MAX  = 8'(MAX_LOCK);

  state_t        r_state, w_state_next;
  logic          r_last, w_last_next;
  logic          r_lock_act, w_lock_act_next;
  logic [7:0]    r_lock_cnt, w_lock_cnt_next;
  logic [2:0]    r_wait_cnt, w_wait_cnt_next;
  logic          r_owner, w_owner_next;
  logic          r_m_en, w_m_en_next;
  logic          r_m_we, w_m_we_next;
  logic [AW-1:0] r_m_addr, w_m_addr_next;
  logic [DW-1:0] r_m_wdata, w_m_wdata_next;
  logic          r_c_gnt, w_c_gnt_next;
  logic          r_l_gnt, w_l_gnt_next;
  logic          r_c_rvalid, w_c_rvalid_next;
  logic          r_l_rvalid, w_l_rvalid_next;
  logic [DW-1:0] r_c_rdata, w_c_rdata_next;
  logic [DW-1:0] r_l_rdata, w_l_rdata_next;

  logic w_lock_eff;
  logic w_pick_l;
  logic w_pick_c;

  // Dropping L_LOCK releases the lock in the same IDLE cycle it is seen.
  assign w_lock_eff = r_lock_act & L_LOCK;
  assign w_pick_l   = L_REQ & (~C_REQ | (w_lock_eff ? (r_lock_cnt < LOCK_MAX) : ~r_last));
  assign w_pick_c   = C_REQ & ~w_pick_l;

  always_ff @(posedge clk) begin
    if (RN) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_lock_act <= 1'b0;
      r_lock_cnt <= '0;
      r_wait_cnt <= '0;
      r_owner    <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_c_gnt    <= 1'b0;
      r_l_gnt    <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_l_rdata  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_lock_act <= w_lock_act_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_owner    <= w_owner_next;
      r_m_en     <= w_m_en_next;
      r_m_we     <= w_m_we_next;
      r_m_addr   <= w_m_addr_next;
      r_m_wdata  <= w_m_wdata_next;
      r_c_gnt    <= w_c_gnt_next;
      r_l_gnt    <= w_l_gnt_next;
      r_c_rvalid <= w_c_rvalid_next;
      r_l_rvalid <= w_l_rvalid_next;
      r_c_rdata  <= w_c_rdata_next;
      r_l_rdata  <= w_l_rdata_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_last_next     = r_last;
    w_lock_act_next = r_lock_act;
    w_lock_cnt_next = r_lock_cnt;
    w_wait_cnt_next = r_wait_cnt;
    w_owner_next    = r_owner;
    w_m_en_next     = 1'b0;
    w_m_we_next     = 1'b0;
    w_m_addr_next   = r_m_addr;
    w_m_wdata_next  = r_m_wdata;
    w_c_gnt_next    = 1'b0;
    w_l_gnt_next    = 1'b0;
    w_c_rvalid_next = 1'b0;
    w_l_rvalid_next = 1'b0;
    w_c_rdata_next  = r_c_rdata;
    w_l_rdata_next  = r_l_rdata;

    case (r_state)
      ST_IDLE: begin
        if (!L_LOCK) begin
          w_lock_act_next = 1'b0;
          w_lock_cnt_next = '0;
        end
        if (w_pick_l) begin
          w_state_next   = ST_ISSUE;
          w_m_en_next    = 1'b1;
          w_m_we_next    = L_WE;
          w_m_addr_next  = L_ADDR;
          w_m_wdata_next = L_WDATA;
          w_l_gnt_next   = 1'b1;
          w_owner_next   = 1'b1;
          w_last_next    = 1'b1;
          if (L_LOCK) w_lock_act_next = 1'b1;
          // Only grants taken while the core is kept waiting use up the lock budget.
          if (w_lock_eff && C_REQ) w_lock_cnt_next = r_lock_cnt + 8'd1;
        end else if (w_pick_c) begin
          w_state_next    = ST_ISSUE;
          w_m_en_next     = 1'b1;
          w_m_we_next     = C_WE;
          w_m_addr_next   = C_ADDR;
          w_m_wdata_next  = C_WDATA;
          w_c_gnt_next    = 1'b1;
          w_owner_next    = 1'b0;
          w_last_next     = 1'b0;
          w_lock_cnt_next = '0;
        end
      end
      ST_ISSUE: begin
        if (r_m_we) begin
          w_state_next = ST_IDLE;
        end else begin
          w_wait_cnt_next = WAIT_LOAD;
          w_state_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_next = ST_IDLE;
          if (r_owner) begin
            w_l_rdata_next  = M_RDATA;
            w_l_rvalid_next = 1'b1;
          end else begin
            w_c_rdata_next  = M_RDATA;
            w_c_rvalid_next = 1'b1;
          end
        end else begin
          w_wait_cnt_next = r_wait_cnt - 3'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign C_GNT    = r_c_gnt;
  assign C_RVALID = r_c_rvalid;
  assign C_RDATA  = r_c_rdata;
  assign C_STALL  = C_REQ & ~r_c_gnt;
  assign L_GNT    = r_l_gnt;
  assign L_RVALID = r_l_rvalid;
  assign L_RDATA  = r_l_rdata;
  assign M_EN     = r_m_en;
  assign M_WE     = r_m_we;
  assign M_ADDR   = r_m_addr;
  assign M_WDATA  = r_m_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 1/3/4, MAX_LOCK 2), each with
// its own latency-accurate memory model; per-cycle vector table plus directed sequences.
module tb_dmem_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic tb_init;
  logic rn [N], c_req [N], c_we [N], l_req [N], l_we [N], l_lock [N];
  logic [AW-1:0] c_addr [N], l_addr [N], m_addr [N];
  logic [DW-1:0] c_wdata [N], l_wdata [N], c_rdata [N], l_rdata [N], m_wdata [N], m_rdata [N];
  logic c_gnt [N], c_rvalid [N], c_stall [N], l_gnt [N], l_rvalid [N], m_en [N], m_we [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    logic [DW-1:0] mem  [32];
    logic [DW-1:0] pipe [LAT];

    // Read data appears exactly LAT cycles after the M_EN cycle; garbage otherwise.
    always @(posedge clk) begin
      if (tb_init) begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
      end else if (m_en[gi] && m_we[gi]) begin
        mem[m_addr[gi]] <= m_wdata[gi];
      end
      pipe[0] <= (m_en[gi] && !m_we[gi]) ? mem[m_addr[gi]] : 32'hDEADBEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[gi] = pipe[LAT-1];

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT), .MAX_LOCK(2)) u_dut (
      .clk      (clk),
      .RN       (rn[gi]),
      .C_REQ    (c_req[gi]),
      .C_WE     (c_we[gi]),
      .C_ADDR   (c_addr[gi]),
      .C_WDATA  (c_wdata[gi]),
      .C_GNT    (c_gnt[gi]),
      .C_RVALID (c_rvalid[gi]),
      .C_RDATA  (c_rdata[gi]),
      .C_STALL  (c_stall[gi]),
      .L_REQ    (l_req[gi]),
      .L_WE     (l_we[gi]),
      .L_ADDR   (l_addr[gi]),
      .L_WDATA  (l_wdata[gi]),
      .L_LOCK   (l_lock[gi]),
      .L_GNT    (l_gnt[gi]),
      .L_RVALID (l_rvalid[gi]),
      .L_RDATA  (l_rdata[gi]),
      .M_EN     (m_en[gi]),
      .M_WE     (m_we[gi]),
      .M_ADDR   (m_addr[gi]),
      .M_WDATA  (m_wdata[gi]),
      .M_RDATA  (m_rdata[gi])
    );
  end

  typedef struct packed {
    logic        rn;
    logic        creq;
    logic        cwe;
    logic [4:0]  caddr;
    logic [31:0] cwdata;
    logic        lreq;
    logic        lwe;
    logic [4:0]  laddr;
    logic [31:0] lwdata;
    logic        llock;
  } in_t;

  // str = {c_gnt, l_gnt, m_en, m_we, c_rvalid, l_rvalid, c_stall}
  typedef struct {
    in_t         stim;
    logic [6:0]  str;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  localparam logic [6:0] E_NONE   = 7'b0000000;
  localparam logic [6:0] E_STALL  = 7'b0000001;
  localparam logic [6:0] E_CGNT_W = 7'b1011000;
  localparam logic [6:0] E_CGNT_R = 7'b1010000;
  localparam logic [6:0] E_LGNT_W = 7'b0111001;
  localparam logic [6:0] E_LGNT_R = 7'b0110000;
  localparam logic [6:0] E_CRV    = 7'b0000100;
  localparam logic [6:0] E_LRV    = 7'b0000010;

  vec_t vecs [$];
  int   n_pass;
  int   n_total;

  function automatic in_t mk_in(logic r, logic cq, logic cw, logic [4:0] ca, logic [31:0] cd,
                                logic lq, logic lw, logic [4:0] la, logic [31:0] ld, logic lk);
    in_t v;
    v = '{rn: r, creq: cq, cwe: cw, caddr: ca, cwdata: cd,
          lreq: lq, lwe: lw, laddr: la, lwdata: ld, llock: lk};
    return v;
  endfunction

  task automatic add(in_t s, logic [6:0] e, logic [4:0] a, logic [31:0] d);
    vecs.push_back('{stim: s, str: e, addr: a, data: d});
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic apply0(in_t s);
    rn[0] = s.rn;     c_req[0] = s.creq;  c_we[0] = s.cwe;  c_addr[0] = s.caddr;
    c_wdata[0] = s.cwdata; l_req[0] = s.lreq; l_we[0] = s.lwe; l_addr[0] = s.laddr;
    l_wdata[0] = s.lwdata; l_lock[0] = s.llock;
  endtask

  function automatic logic [31:0] strobes(int k);
    return 32'({c_gnt[k], l_gnt[k], m_en[k], m_we[k], c_rvalid[k], l_rvalid[k], c_stall[k]});
  endfunction

  in_t IN_RST, IN_IDLE, IN_CW3, IN_CR3, IN_BOTH, IN_BOTHLK, IN_LR6;
  logic [6:0] lock_order;
  logic [2:0] rr_order;
  logic [4:0] a;

  initial begin
    n_pass  = 0;
    n_total = 0;
    tb_init = 1'b1;
    for (int k = 0; k < N; k++) begin
      rn[k] = 1'b1; c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      l_req[k] = 1'b0; l_we[k] = 1'b0; l_addr[k] = '0; l_wdata[k] = '0; l_lock[k] = 1'b0;
    end

    IN_RST    = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    IN_IDLE   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    IN_CW3    = mk_in(0, 1, 1, 3, 32'h3, 0, 0, 0, 0, 0);
    IN_CR3    = mk_in(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    IN_BOTH   = mk_in(0, 1, 1, 5, 32'h55, 1, 1, 6, 32'h66, 0);
    IN_BOTHLK = mk_in(0, 1, 1, 5, 32'h55, 1, 1, 6, 32'h66, 1);
    IN_LR6    = mk_in(0, 0, 0, 0, 0, 1, 0, 6, 0, 0);
    lock_order = 7'b1110110;   // L L L C L L C
    rr_order   = 3'b101;       // L C L after the lock is dropped

    add(IN_RST,  E_NONE,   0, 0);
    add(IN_CW3,  E_STALL,  0, 0);
    add(IN_CW3,  E_CGNT_W, 3, 32'h3);
    add(IN_IDLE, E_NONE,   0, 0);
    add(IN_CR3,  E_STALL,  0, 0);
    add(IN_CR3,  E_CGNT_R, 3, 0);
    add(IN_IDLE, E_NONE,   0, 0);
    add(IN_RST,  E_CRV,    0, 32'h3);
    for (int r = 0; r < 2; r++) begin
      add(IN_BOTH, E_STALL,  0, 0);
      add(IN_BOTH, E_CGNT_W, 5, 32'h55);
      add(IN_BOTH, E_STALL,  0, 0);
      add(IN_BOTH, E_LGNT_W, 6, 32'h66);
    end
    add(IN_BOTHLK, E_STALL,  0, 0);
    add(IN_BOTHLK, E_CGNT_W, 5, 32'h55);
    for (int j = 6; j >= 0; j--) begin
      add(IN_BOTHLK, E_STALL, 0, 0);
      if (lock_order[j]) add(IN_BOTHLK, E_LGNT_W, 6, 32'h66);
      else               add(IN_BOTHLK, E_CGNT_W, 5, 32'h55);
    end
    for (int j = 2; j >= 0; j--) begin
      add(IN_BOTH, E_STALL, 0, 0);
      if (rr_order[j]) add(IN_BOTH, E_LGNT_W, 6, 32'h66);
      else             add(IN_BOTH, E_CGNT_W, 5, 32'h55);
    end
    add(IN_LR6,  E_NONE,   0, 0);
    add(IN_LR6,  E_LGNT_R, 6, 0);
    add(IN_IDLE, E_NONE,   0, 0);
    add(IN_IDLE, E_LRV,    0, 32'h66);

    repeat (3) @(negedge clk);
    tb_init = 1'b0;

    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset strobes inst%0d", k), strobes(k), 32'h0);
      chk($sformatf("reset m_addr inst%0d", k),  32'(m_addr[k]), 32'h0);
      chk($sformatf("reset m_wdata inst%0d", k), m_wdata[k], 32'h0);
      chk($sformatf("reset c_rdata inst%0d", k), c_rdata[k], 32'h0);
      chk($sformatf("reset l_rdata inst%0d", k), l_rdata[k], 32'h0);
    end
    rn[1] = 1'b0;
    rn[2] = 1'b0;

    // Per-cycle table on instance 0 (RD_LAT=1)
    for (int i = 0; i < vecs.size(); i++) begin
      apply0(vecs[i].stim);
      #1;
      chk($sformatf("vec%0d strobes", i), strobes(0), 32'(vecs[i].str));
      if (vecs[i].str[4]) chk($sformatf("vec%0d m_addr", i), 32'(m_addr[0]), 32'(vecs[i].addr));
      if (vecs[i].str[4] && vecs[i].str[3]) chk($sformatf("vec%0d m_wdata", i), m_wdata[0], vecs[i].data);
      if (vecs[i].str[2]) chk($sformatf("vec%0d c_rdata", i), c_rdata[0], vecs[i].data);
      if (vecs[i].str[1]) chk($sformatf("vec%0d l_rdata", i), l_rdata[0], vecs[i].data);
      $display("vec %0d: c_gnt=%b l_gnt=%b m_en=%b m_we=%b c_rvalid=%b l_rvalid=%b c_stall=%b",
               i, c_gnt[0], l_gnt[0], m_en[0], m_we[0], c_rvalid[0], l_rvalid[0], c_stall[0]);
      @(negedge clk);
    end

    // Reset during WAIT of a loader read on instance 1 (RD_LAT=3)
    l_req[1] = 1'b1; l_we[1] = 1'b0; l_addr[1] = 5'd9;
    @(negedge clk);
    chk("rstwait l_gnt", 32'(l_gnt[1]), 32'h1);
    l_req[1] = 1'b0;
    @(negedge clk);
    chk("rstwait m_en in wait", 32'(m_en[1]), 32'h0);
    rn[1] = 1'b1;
    @(negedge clk);
    chk("rstwait strobes", strobes(1), 32'h0);
    chk("rstwait m_addr", 32'(m_addr[1]), 32'h0);
    chk("rstwait m_wdata", m_wdata[1], 32'h0);
    chk("rstwait l_rdata", l_rdata[1], 32'h0);
    rn[1] = 1'b0; c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 5'd1; c_wdata[1] = 32'h11;
    #1;
    chk("rstwait c_stall", 32'(c_stall[1]), 32'h1);
    @(negedge clk);
    chk("rstwait c_gnt after release", 32'(c_gnt[1]), 32'h1);
    chk("rstwait c write addr", 32'(m_addr[1]), 32'h1);
    $display("inst1 core write after reset: c_gnt=%b m_addr=%0d", c_gnt[1], m_addr[1]);
    c_req[1] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("rstwait no l_rvalid %0d", j), 32'(l_rvalid[1]), 32'h0);
    end

    // Back-to-back core reads on instance 2 (RD_LAT=4), addresses 0..31 then wrap to 0
    a = 5'd0;
    c_req[2] = 1'b1; c_we[2] = 1'b0; c_addr[2] = a;
    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      chk($sformatf("sweep%0d c_gnt", i), 32'(c_gnt[2]), 32'h1);
      chk($sformatf("sweep%0d m_addr", i), 32'(m_addr[2]), 32'(a));
      @(negedge clk);
      c_addr[2] = a + 5'd1;
      if (i == 32) c_req[2] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk($sformatf("sweep%0d early rvalid %0d", i, j), 32'({c_rvalid[2], c_gnt[2]}), 32'h0);
      end
      @(negedge clk);
      chk($sformatf("sweep%0d c_rvalid", i), 32'(c_rvalid[2]), 32'h1);
      chk($sformatf("sweep%0d c_rdata", i), c_rdata[2], 32'hC0DE0000 + 32'(a));
      $display("inst2 read addr %0d: c_rvalid=%b c_rdata=%h", a, c_rvalid[2], c_rdata[2]);
      a = a + 5'd1;
      @(negedge clk);
    end
    chk("sweep idle after last", 32'(c_gnt[2]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
